passcode_checker: RTL and testbench

Consumes the keypad decoder's `digit`/`valid` stream and assembles fixed-length code entries. Compares each complete entry against a parameterised passcode. Drives the timed `unlock` output on a match and an `error` pulse on a mismatch. Escalates to a timed alarm lockout after repeated consecutive failures.

---
 rtl/passcode_checker.sv | 168 ++++++++++++++++
 tb/tb_passcode_checker.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/passcode_checker.sv
// passcode_checker
//   Collects keypad digits from the decoder's digit/valid stream into fixed-length
//   entries and compares each complete entry against PASSCODE. A match holds
//   `unlock` for UNLOCK_CYCLES cycles. A mismatch pulses `error` and bumps the
//   consecutive-failure count.
//   Optional feature macro: PASSCODE_LOCKOUT_EN. When it is defined, MAX_FAILS
//   consecutive mismatches hold `alarm` for LOCKOUT_CYCLES cycles. When it is
//   undefined, `alarm` is tied low and every mismatch returns to digit entry.
module passcode_checker #(
    parameter int unsigned           CODE_LEN       = 4,
    parameter logic [4*CODE_LEN-1:0] PASSCODE       = 16'h1234,
    parameter int unsigned           MAX_FAILS      = 3,
    parameter int unsigned           UNLOCK_CYCLES  = 1000,
    parameter int unsigned           LOCKOUT_CYCLES = 5000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [3:0]                       digit,
    input  logic                             valid,
    output logic                             unlock,
    output logic                             alarm,
    output logic                             error,
    output logic [$clog2(CODE_LEN+1)-1:0]    entered_count,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

    localparam int unsigned CNT_W   = $clog2(CODE_LEN + 1);
    localparam int unsigned FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int unsigned MAX_CYC = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                       : LOCKOUT_CYCLES;
    localparam int unsigned TMR_RAW = $clog2(MAX_CYC);
    // A single-cycle hold time still needs one timer bit.
    localparam int unsigned TMR_W   = (TMR_RAW < 1) ? 1 : TMR_RAW;

    localparam logic [CNT_W-1:0]  LAST_DIGIT  = CNT_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX    = FAIL_W'(MAX_FAILS);
    localparam logic [TMR_W-1:0]  UNLOCK_LOAD = TMR_W'(UNLOCK_CYCLES - 1);
`ifdef PASSCODE_LOCKOUT_EN
    localparam logic [TMR_W-1:0]  LOCK_LOAD   = TMR_W'(LOCKOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_CHECK   = 2'd1,
        ST_OPEN    = 2'd2
`ifdef PASSCODE_LOCKOUT_EN
        , ST_LOCKOUT = 2'd3
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [4*CODE_LEN-1:0]   code_q, code_d, code_shift;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [CNT_W-1:0]        count_d;
    logic [FAIL_W-1:0]       fail_d, fail_inc;
    logic                    error_d;

    // New digit enters at the low nibble; older digits move toward the MSB.
    if (CODE_LEN == 1) begin : g_shift_one
        assign code_shift = digit;
    end else begin : g_shift_many
        assign code_shift = {code_q[4*CODE_LEN-5:0], digit};
    end

    // Saturating increment of the consecutive-failure count.
    assign fail_inc = (fail_count == FAIL_MAX) ? fail_count : fail_count + FAIL_W'(1);

    // Next-state and next-datapath decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        code_d  = code_q;
        count_d = entered_count;
        fail_d  = fail_count;
        timer_d = (timer_q != '0) ? timer_q - TMR_W'(1) : timer_q;
        error_d = 1'b0;

        case (state_q)
            ST_ENTRY: begin
                if (valid) begin
                    if (digit == 4'hF) begin
                        // Clear key restarts the entry; the buffer is refilled anyway.
                        count_d = '0;
                    end else begin
                        code_d  = code_shift;
                        count_d = entered_count + CNT_W'(1);
                        if (entered_count == LAST_DIGIT) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
            end

            ST_CHECK: begin
                count_d = '0;
                if (code_q == PASSCODE) begin
                    state_d = ST_OPEN;
                    fail_d  = '0;
                    timer_d = UNLOCK_LOAD;
                end else begin
                    fail_d  = fail_inc;
                    error_d = 1'b1;
                    state_d = ST_ENTRY;
`ifdef PASSCODE_LOCKOUT_EN
                    if (fail_inc == FAIL_MAX) begin
                        state_d = ST_LOCKOUT;
                        timer_d = LOCK_LOAD;
                    end
`endif
                end
            end

            ST_OPEN: begin
                if (timer_q == '0) begin
                    state_d = ST_ENTRY;
                end
            end

`ifdef PASSCODE_LOCKOUT_EN
            ST_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = ST_ENTRY;
                    fail_d  = '0;
                end
            end
`endif

            default: begin
                state_d = ST_ENTRY;
                count_d = '0;
            end
        endcase
    end

    // State, datapath and registered outputs; reset clears all of them at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_ENTRY;
            code_q        <= '0;
            timer_q       <= '0;
            entered_count <= '0;
            fail_count    <= '0;
            unlock        <= 1'b0;
            error         <= 1'b0;
`ifdef PASSCODE_LOCKOUT_EN
            alarm         <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            code_q        <= code_d;
            timer_q       <= timer_d;
            entered_count <= count_d;
            fail_count    <= fail_d;
            unlock        <= (state_d == ST_OPEN);
            error         <= error_d;
`ifdef PASSCODE_LOCKOUT_EN
            alarm         <= (state_d == ST_LOCKOUT);
`endif
        end
    end

`ifndef PASSCODE_LOCKOUT_EN
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_passcode_checker.sv
// tb_passcode_checker
//   Directed tables and sequences for the corner cases, then randomized key
//   traffic compared every cycle against a queue-based reference model.
//   Expectations follow PASSCODE_LOCKOUT_EN in the same way as the design.
module tb_passcode_checker;

    localparam int              CODE_LEN = 4;
    localparam logic [15:0]     PASSCODE = 16'h1234;
    localparam int              MAX_FAILS = 3;
    localparam int              UNLOCK_N  = 8;
    localparam int              LOCKOUT_N = 16;
`ifdef PASSCODE_LOCKOUT_EN
    localparam bit              LOCK_EN   = 1'b1;
`else
    localparam bit              LOCK_EN   = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] digit = 4'h0;
    logic       valid = 1'b0;
    logic       unlock, alarm, error;
    logic [2:0] entered_count;
    logic [1:0] fail_count;

    int n_vec = 0;
    int n_err = 0;

    passcode_checker #(
        .CODE_LEN       (CODE_LEN),
        .PASSCODE       (PASSCODE),
        .MAX_FAILS      (MAX_FAILS),
        .UNLOCK_CYCLES  (UNLOCK_N),
        .LOCKOUT_CYCLES (LOCKOUT_N)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .digit         (digit),
        .valid         (valid),
        .unlock        (unlock),
        .alarm         (alarm),
        .error         (error),
        .entered_count (entered_count),
        .fail_count    (fail_count)
    );

    always #5 clk = ~clk;

    // Watchdog: a hung run still reports and stops.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Digits of the current entry, consecutive failures, cycles left in the
    // timed states, and whether a full entry awaits its comparison cycle.
    int m_digits[$];
    int m_fails;
    int m_open_left;
    int m_alarm_left;
    bit m_pending;
    bit m_err;

    function automatic void model_reset();
        m_digits.delete();
        m_fails      = 0;
        m_open_left  = 0;
        m_alarm_left = 0;
        m_pending    = 1'b0;
        m_err        = 1'b0;
    endfunction

    function automatic void model_step(input bit v, input logic [3:0] d);
        int code;
        m_err = 1'b0;
        if (m_open_left > 0) begin
            m_open_left--;
        end else if (m_alarm_left > 0) begin
            m_alarm_left--;
            if (m_alarm_left == 0) m_fails = 0;
        end else if (m_pending) begin
            code = 0;
            foreach (m_digits[i]) code = code * 16 + m_digits[i];
            if (code == int'(PASSCODE)) begin
                m_open_left = UNLOCK_N;
                m_fails     = 0;
            end else begin
                m_err   = 1'b1;
                m_fails = (m_fails < MAX_FAILS) ? m_fails + 1 : MAX_FAILS;
                if (LOCK_EN && m_fails == MAX_FAILS) m_alarm_left = LOCKOUT_N;
            end
            m_digits.delete();
            m_pending = 1'b0;
        end else if (v) begin
            if (d == 4'hF) begin
                m_digits.delete();
            end else begin
                m_digits.push_back(int'(d));
                if (m_digits.size() == CODE_LEN) m_pending = 1'b1;
            end
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("model_unlock", int'(unlock), int'(m_open_left > 0));
        check("model_alarm",  int'(alarm),  int'(m_alarm_left > 0));
        check("model_error",  int'(error),  int'(m_err));
        check("model_count",  int'(entered_count), m_digits.size());
        check("model_fails",  int'(fail_count), m_fails);
    endtask

    // One clock: drive on the falling edge, model on the rising edge, compare 1 after.
    task automatic step(input bit v, input logic [3:0] d);
        @(negedge clk);
        valid = v;
        digit = d;
        @(posedge clk);
        model_step(v, d);
        #1;
        compare_all();
    endtask

    task automatic enter(input logic [15:0] code);
        logic [15:0] c;
        c = code;
        for (int k = 3; k >= 0; k--) step(1'b1, c[4*k +: 4]);
    endtask

    // Idle while unlock is high; returns how many idle cycles saw it high.
    task automatic drain_unlock(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 4'h0);
            if (unlock) cnt++;
            else break;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid = 1'b0;
        digit = 4'h0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit         v;
        logic [3:0] d;
        int         unl;
        int         err;
        int         cnt;
    } vec_t;

    vec_t       tbl [9];
    logic [3:0] pool [7];

    initial begin
        int cnt;
        int acnt;
        int errs;
        int mode;
        int gap;
        logic [15:0] pc;

        tbl[0] = '{1'b1, 4'h1, 0, 0, 1};
        tbl[1] = '{1'b1, 4'h2, 0, 0, 2};
        tbl[2] = '{1'b1, 4'hF, 0, 0, 0};
        tbl[3] = '{1'b1, 4'h1, 0, 0, 1};
        tbl[4] = '{1'b1, 4'h2, 0, 0, 2};
        tbl[5] = '{1'b1, 4'h3, 0, 0, 3};
        tbl[6] = '{1'b1, 4'h4, 0, 0, 4};
        tbl[7] = '{1'b0, 4'h0, 1, 0, 0};
        tbl[8] = '{1'b0, 4'h0, 1, 0, 0};
        pool   = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h9, 4'hA, 4'hF};
        pc     = PASSCODE;

        // Reset state.
        do_reset();
        check("rst_unlock", int'(unlock), 0);
        check("rst_alarm",  int'(alarm), 0);
        check("rst_error",  int'(error), 0);
        check("rst_count",  int'(entered_count), 0);
        check("rst_fails",  int'(fail_count), 0);

        // Correct code: unlock for exactly UNLOCK_N cycles, no error.
        enter(16'h1234);
        check("ok_count_at_check", int'(entered_count), 4);
        drain_unlock(cnt);
        check("ok_unlock_len", cnt, UNLOCK_N);
        check("ok_fails", int'(fail_count), 0);

        // Clear key mid-entry, back-to-back strobes.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].v, tbl[i].d);
            check("tbl_unlock", int'(unlock), tbl[i].unl);
            check("tbl_error",  int'(error), tbl[i].err);
            check("tbl_count",  int'(entered_count), tbl[i].cnt);
        end
        drain_unlock(cnt);
        check("tbl_unlock_len", cnt + 2, UNLOCK_N);

        // Mismatch then match.
        enter(16'h1235);
        step(1'b0, 4'h0);
        check("mm_error", int'(error), 1);
        check("mm_fails", int'(fail_count), 1);
        step(1'b0, 4'h0);
        check("mm_error_one_cycle", int'(error), 0);
        enter(16'h1234);
        step(1'b0, 4'h0);
        check("mm_then_unlock", int'(unlock), 1);
        check("mm_fails_cleared", int'(fail_count), 0);
        drain_unlock(cnt);

        // Repeated failures.
        errs = 0;
`ifdef PASSCODE_LOCKOUT_EN
        for (int i = 0; i < 3; i++) begin
            enter(16'h9999);
            step(1'b0, 4'h0);
            if (error) errs++;
        end
        check("lock_alarm_on", int'(alarm), 1);
        check("lock_fails", int'(fail_count), MAX_FAILS);
        acnt = 1;
        for (int k = 3; k >= 0; k--) begin
            step(1'b1, pc[4*k +: 4]);
            check("lock_ignore_unlock", int'(unlock), 0);
            check("lock_ignore_count", int'(entered_count), 0);
            if (alarm) acnt++;
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 4'h0);
            if (alarm) acnt++;
            else break;
        end
        check("lock_alarm_len", acnt, LOCKOUT_N);
        check("lock_fails_cleared", int'(fail_count), 0);
        check("lock_errors", errs, 3);
        enter(16'h1234);
        step(1'b0, 4'h0);
        check("lock_after_unlock", int'(unlock), 1);
        drain_unlock(cnt);
`else
        for (int i = 0; i < 4; i++) begin
            enter(16'h9999);
            step(1'b0, 4'h0);
            if (error) errs++;
            check("nolock_alarm", int'(alarm), 0);
        end
        check("nolock_fails_sat", int'(fail_count), MAX_FAILS);
        check("nolock_errors", errs, 4);
`endif

        // Keys ignored while OPEN.
        enter(16'h1234);
        step(1'b0, 4'h0);
        acnt = int'(unlock);
        for (int k = 3; k >= 0; k--) begin
            step(1'b1, pc[4*k +: 4]);
            check("busy_count", int'(entered_count), 0);
            if (unlock) acnt++;
        end
        drain_unlock(cnt);
        check("busy_unlock_len", acnt + cnt, UNLOCK_N);

        // Asynchronous reset in the middle of OPEN.
        enter(16'h1234);
        step(1'b0, 4'h0);
        step(1'b0, 4'h0);
        check("pre_rst_unlock", int'(unlock), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_unlock", int'(unlock), 0);
        check("async_rst_alarm",  int'(alarm), 0);
        check("async_rst_error",  int'(error), 0);
        check("async_rst_count",  int'(entered_count), 0);
        check("async_rst_fails",  int'(fail_count), 0);
        do_reset();

        // Randomized traffic against the model.
        for (int it = 0; it < 300; it++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: begin
                    for (int k = 3; k >= 0; k--) begin
                        step(1'b1, pc[4*k +: 4]);
                        gap = int'($urandom_range(0, 1));
                        if (gap != 0) step(1'b0, 4'h0);
                    end
                end
                1: repeat (CODE_LEN) step(1'b1, pool[$urandom_range(0, 6)]);
                2: repeat ($urandom_range(1, 12)) step(1'b0, 4'h0);
                default: step(bit'($urandom_range(0, 1)), pool[$urandom_range(0, 6)]);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
